wb_arbiter: RTL

Writeback arbiter between the execution units and the issue-queue writeback bus. Accepts completed results (physical destination register plus 32-bit data) from NUM_SRC execution units through valid/ready handshakes, buffers them in small per-source FIFOs, and each cycle forwards up to DISPATCH_WIDTH of them, chosen round-robin, onto the registered writeback bus. Its writeback outputs drive the issue queue's wakeup and the physical register file write ports.

---
 rtl/wb_arbiter_if.sv | 29 ++
 rtl/wb_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Bundles the execution-unit result handshakes and the writeback bus.
// master = result producers / writeback consumer, slave = the arbiter.
// Purely structural; no timing or flow control lives here.
interface wb_arbiter_if #(
    parameter int DISPATCH_WIDTH       = 2,
    parameter int PHYS_REGS_ADDR_WIDTH = 6,
    parameter int NUM_SRC              = 3
);
    // Result sources, one lane per execution unit
    logic [NUM_SRC-1:0]                                src_valid;
    logic [NUM_SRC-1:0]                                src_ready;
    logic [NUM_SRC-1:0][PHYS_REGS_ADDR_WIDTH-1:0]      src_phys_rd;
    logic [NUM_SRC-1:0][31:0]                          src_data;

    // Registered writeback slots, no backpressure
    logic [DISPATCH_WIDTH-1:0]                         wb_valid;
    logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd;
    logic [DISPATCH_WIDTH-1:0][31:0]                   wb_data;

    modport master (
        output src_valid, src_phys_rd, src_data,
        input  src_ready, wb_valid, wb_phys_rd, wb_data
    );

    modport slave (
        input  src_valid, src_phys_rd, src_data,
        output src_ready, wb_valid, wb_phys_rd, wb_data
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs drained round-robin onto DISPATCH_WIDTH wb slots.
// Latency: result accepted at edge E appears on wb_* after edge E+1 at the earliest.
// Backpressure: src_ready drops only when a source FIFO is full (registered count); wb bus never stalls.
module wb_arbiter #(
    parameter int DISPATCH_WIDTH       = 2,
    parameter int PHYS_REGS_ADDR_WIDTH = 6,
    parameter int NUM_SRC              = 3,
    parameter int FIFO_DEPTH           = 2
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
        logic [31:0]                     data;
    } entry_t;

    // Per-source FIFO state
    entry_t           mem_q   [NUM_SRC][FIFO_DEPTH];
    entry_t           mem_d   [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0] head_q  [NUM_SRC];
    logic [PTR_W-1:0] head_d  [NUM_SRC];
    logic [PTR_W-1:0] tail_q  [NUM_SRC];
    logic [PTR_W-1:0] tail_d  [NUM_SRC];
    logic [CNT_W-1:0] count_q [NUM_SRC];
    logic [CNT_W-1:0] count_d [NUM_SRC];

    // Arbitration state
    logic [SRC_W-1:0] rr_ptr_q;
    logic [SRC_W-1:0] rr_ptr_d;

    // Writeback slot registers
    logic [DISPATCH_WIDTH-1:0] wb_valid_q;
    logic [DISPATCH_WIDTH-1:0] wb_valid_d;
    entry_t                    wb_entry_q [DISPATCH_WIDTH];
    entry_t                    wb_entry_d [DISPATCH_WIDTH];

    // Per-cycle handshake and grant results
    logic [NUM_SRC-1:0]        src_rdy;
    logic [NUM_SRC-1:0]        push;
    logic [NUM_SRC-1:0]        grant;
    logic [DISPATCH_WIDTH-1:0] slot_vld;
    logic [SRC_W-1:0]          slot_src [DISPATCH_WIDTH];

    // Ready depends only on the registered count, so a pop this cycle cannot open the door early
    always_comb begin
        src_rdy = '0;
        push    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_rdy[i] = (count_q[i] != CNT_W'(FIFO_DEPTH));
            push[i]    = bus.src_valid[i] & src_rdy[i];
        end
    end

    // Round-robin scan from rr_ptr: first DISPATCH_WIDTH non-empty sources fill slots in scan order
    always_comb begin
        logic [SRC_W:0]   sum;
        logic [SRC_W-1:0] idx;
        logic [SRC_W-1:0] last;
        int               n;
        grant    = '0;
        slot_vld = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            slot_src[k] = '0;
        end
        sum  = '0;
        idx  = '0;
        last = rr_ptr_q;
        n    = 0;
        for (int j = 0; j < NUM_SRC; j++) begin
            sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(j);
            if (sum >= (SRC_W+1)'(NUM_SRC)) begin
                sum = sum - (SRC_W+1)'(NUM_SRC);
            end
            idx = sum[SRC_W-1:0];
            if ((count_q[idx] != '0) && (n < DISPATCH_WIDTH)) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                    if (k == n) begin
                        slot_vld[k] = 1'b1;
                        slot_src[k] = idx;
                    end
                end
                last = idx;
                n    = n + 1;
            end
        end
        // Next scan starts just past the last source served; idle cycles leave it alone
        if (n != 0) begin
            rr_ptr_d = (last == SRC_W'(NUM_SRC - 1)) ? '0 : last + 1'b1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // FIFO bookkeeping: push at tail, pop at head, both may happen in the same cycle
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            head_d[i]  = head_q[i];
            tail_d[i]  = tail_q[i];
            count_d[i] = count_q[i];
            for (int d = 0; d < FIFO_DEPTH; d++) begin
                mem_d[i][d] = mem_q[i][d];
            end
            if (push[i]) begin
                mem_d[i][tail_q[i]] = '{phys_rd: bus.src_phys_rd[i], data: bus.src_data[i]};
                // Depth is a power of two, so the pointer wraps naturally
                tail_d[i] = tail_q[i] + 1'b1;
            end
            if (grant[i]) begin
                head_d[i] = head_q[i] + 1'b1;
            end
            count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(grant[i]);
        end
    end

    // Load granted heads into their slots; idle slots drop valid but keep the last payload
    always_comb begin
        wb_valid_d = slot_vld;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            wb_entry_d[k] = wb_entry_q[k];
            if (slot_vld[k]) begin
                wb_entry_d[k] = mem_q[slot_src[k]][head_q[slot_src[k]]];
            end
        end
    end

    // State register; reset discards buffered results and clears the writeback bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            wb_valid_q <= '0;
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                wb_entry_q[k] <= '0;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
                for (int d = 0; d < FIFO_DEPTH; d++) begin
                    mem_q[i][d] <= '0;
                end
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wb_valid_q <= wb_valid_d;
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                wb_entry_q[k] <= wb_entry_d[k];
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                head_q[i]  <= head_d[i];
                tail_q[i]  <= tail_d[i];
                count_q[i] <= count_d[i];
                for (int d = 0; d < FIFO_DEPTH; d++) begin
                    mem_q[i][d] <= mem_d[i][d];
                end
            end
        end
    end

    assign bus.src_ready = src_rdy;
    assign bus.wb_valid  = wb_valid_q;

    // Unpack slot registers onto the bus
    always_comb begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            bus.wb_phys_rd[k] = wb_entry_q[k].phys_rd;
            bus.wb_data[k]    = wb_entry_q[k].data;
        end
    end

endmodule
